// File: rtl/bdc_pkg.sv
// rtl/bdc_pkg.sv - shared constants and parser state encoding for the BDC command path
package bdc_pkg;

    localparam logic [7:0] HDR1_BYTE   = 8'h55;
    localparam logic [7:0] HDR2_BYTE   = 8'hAA;

    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_LEN     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        ST_HDR1,
        ST_HDR2,
        ST_CMD,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM
    } parser_state_e;

endpackage

// File: rtl/gap_timer.sv
// rtl/gap_timer.sv - inter-byte gap counter with a one-cycle expiry pulse
module gap_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;

    // Expiry fires as the count reaches TIMEOUT_CYCLES-1, so the registered
    // error lands TIMEOUT_CYCLES cycles after the clearing capture.
    always_comb begin
        cnt_inc = cnt_q + CW'(1);
        cnt_d   = cnt_q;
        expire  = 1'b0;
        if (clear || !run) begin
            cnt_d = '0;
        end else if (cnt_inc == CW'(TIMEOUT_CYCLES - 1)) begin
            expire = 1'b1;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - pops UART bytes from the RX FIFO and decodes 55 AA CMD LEN PAYLOAD CSUM frames
module uart_cmd_parser
    import bdc_pkg::*;
#(
    parameter int unsigned MAX_LEN        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_rd,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic [2:0]  cmd_len,
    output logic [31:0] cmd_payload,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [7:0]  frame_cnt,
    output logic [7:0]  err_cnt
);

    parser_state_e state_q, state_d;

    logic        fifo_rd_q, fifo_rd_d;
    logic        cap_q;
    logic [7:0]  csum_q, csum_d;
    logic [7:0]  code_sh_q, code_sh_d;
    logic [2:0]  len_sh_q, len_sh_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] pay_sh_q, pay_sh_d;

    logic        cmd_valid_q, cmd_valid_d;
    logic [7:0]  cmd_code_q, cmd_code_d;
    logic [2:0]  cmd_len_q, cmd_len_d;
    logic [31:0] cmd_payload_q, cmd_payload_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic        expire;
    logic        timer_run;
    logic [7:0]  csum_acc;

    assign timer_run = (state_q != ST_HDR1);

    gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (cap_q),
        .run    (timer_run),
        .expire (expire)
    );

    always_comb begin
        state_d       = state_q;
        fifo_rd_d     = !fifo_empty && !fifo_rd_q;
        csum_d        = csum_q;
        code_sh_d     = code_sh_q;
        len_sh_d      = len_sh_q;
        idx_d         = idx_q;
        pay_sh_d      = pay_sh_q;
        cmd_valid_d   = 1'b0;
        cmd_code_d    = cmd_code_q;
        cmd_len_d     = cmd_len_q;
        cmd_payload_d = cmd_payload_q;
        err_d         = 1'b0;
        err_code_d    = err_code_q;
        csum_acc      = csum_q + fifo_data;

        // A capture takes priority over a simultaneous gap expiry.
        if (cap_q) begin
            case (state_q)
                ST_HDR1: begin
                    if (fifo_data == HDR1_BYTE) state_d = ST_HDR2;
                end
                ST_HDR2: begin
                    if (fifo_data == HDR2_BYTE)      state_d = ST_CMD;
                    else if (fifo_data == HDR1_BYTE) state_d = ST_HDR2;
                    else                             state_d = ST_HDR1;
                end
                ST_CMD: begin
                    code_sh_d = fifo_data;
                    csum_d    = fifo_data;
                    pay_sh_d  = '0;
                    idx_d     = '0;
                    state_d   = ST_LEN;
                end
                ST_LEN: begin
                    csum_d   = csum_acc;
                    len_sh_d = fifo_data[2:0];
                    if (fifo_data > 8'(MAX_LEN)) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_LEN;
                        state_d    = ST_HDR1;
                    end else if (fifo_data == 8'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    pay_sh_d[{idx_q[1:0], 3'b000} +: 8] = fifo_data;
                    csum_d = csum_acc;
                    idx_d  = idx_q + 3'd1;
                    if (idx_q + 3'd1 == len_sh_q) state_d = ST_CSUM;
                end
                ST_CSUM: begin
                    if (fifo_data == csum_q) begin
                        cmd_valid_d   = 1'b1;
                        cmd_code_d    = code_sh_q;
                        cmd_len_d     = len_sh_q;
                        cmd_payload_d = pay_sh_q;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_CSUM;
                    end
                    state_d = ST_HDR1;
                end
                default: state_d = ST_HDR1;
            endcase
        end else if (expire) begin
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
            state_d    = ST_HDR1;
        end

        frame_cnt_d = frame_cnt_q;
        if (cmd_valid_d && frame_cnt_q != 8'hFF) frame_cnt_d = frame_cnt_q + 8'd1;
        err_cnt_d = err_cnt_q;
        if (err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_HDR1;
            fifo_rd_q     <= 1'b0;
            cap_q         <= 1'b0;
            csum_q        <= '0;
            code_sh_q     <= '0;
            len_sh_q      <= '0;
            idx_q         <= '0;
            pay_sh_q      <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_code_q    <= '0;
            cmd_len_q     <= '0;
            cmd_payload_q <= '0;
            err_q         <= 1'b0;
            err_code_q    <= '0;
            frame_cnt_q   <= '0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            fifo_rd_q     <= fifo_rd_d;
            cap_q         <= fifo_rd_q;
            csum_q        <= csum_d;
            code_sh_q     <= code_sh_d;
            len_sh_q      <= len_sh_d;
            idx_q         <= idx_d;
            pay_sh_q      <= pay_sh_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_code_q    <= cmd_code_d;
            cmd_len_q     <= cmd_len_d;
            cmd_payload_q <= cmd_payload_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
            frame_cnt_q   <= frame_cnt_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign fifo_rd     = fifo_rd_q;
    assign cmd_valid   = cmd_valid_q;
    assign cmd_code    = cmd_code_q;
    assign cmd_len     = cmd_len_q;
    assign cmd_payload = cmd_payload_q;
    assign err         = err_q;
    assign err_code    = err_code_q;
    assign frame_cnt   = frame_cnt_q;
    assign err_cnt     = err_cnt_q;

endmodule
